// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: start, DATA_WIDTH data bits LSB-first, optional parity,
// 1 or 2 stop bits. Per-frame settings are latched on the valid/ready handshake.
module uart_tx_cfg #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic                  parity_EN,
    input  logic                  parity_type,
    input  logic                  stop2,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int unsigned IdxW = $clog2(DATA_WIDTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                 state_q, state_d;
    logic [PRESCALE_W-1:0]  cnt_q, cnt_d;
    logic [PRESCALE_W-1:0]  pre_q, pre_d;
    logic [IdxW-1:0]        bit_q, bit_d;
    logic [IdxW-1:0]        bit_nxt;
    logic                   stop_q, stop_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   par_en_q, par_en_d;
    logic                   par_type_q, par_type_d;
    logic                   stop2_q, stop2_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;

    logic bit_end;
    logic last_stop;
    logic accept;

    assign bit_end    = (cnt_q == pre_q);
    assign last_stop  = (state_q == StStop) && bit_end && (stop_q || !stop2_q);
    assign data_ready = !RST && ((state_q == StIdle) || last_stop);
    assign accept     = data_valid && data_ready;
    assign bit_nxt    = bit_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pre_d      = pre_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        stop2_d    = stop2_q;
        tx_d       = tx_q;
        busy_d     = busy_q;

        if (state_q != StIdle) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_q == LastIdx) begin
                        if (par_en_q) begin
                            state_d = StParity;
                            tx_d    = (^data_q) ^ par_type_q;
                        end else begin
                            state_d = StStop;
                            stop_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = data_q[bit_nxt];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end && stop2_q && !stop_q) begin
                    stop_d = 1'b1;
                end else if (bit_end) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Accept overrides the stop-end return to idle, giving gapless back-to-back frames.
        if (accept) begin
            state_d    = StStart;
            cnt_d      = '0;
            bit_d      = '0;
            stop_d     = 1'b0;
            data_d     = data_in;
            par_en_d   = parity_EN;
            par_type_d = parity_type;
            stop2_d    = stop2;
            pre_d      = prescale;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pre_q      <= '0;
            bit_q      <= '0;
            stop_q     <= 1'b0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            stop2_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pre_q      <= pre_d;
            bit_q      <= bit_d;
            stop_q     <= stop_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            stop2_q    <= stop2_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8-bit build plus a 5-bit build with a 4-bit prescaler.
module tb_uart_tx_cfg;

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic        dv, dr, pen, pty, s2, tx, bsy;
    logic [15:0] pre;

    logic [4:0]  d5_din;
    logic        d5_dv, d5_dr, d5_tx, d5_bsy;
    logic        d5_pen, d5_pty, d5_s2;
    logic [3:0]  d5_pre;

    int n_cmp = 0;
    int n_bad = 0;

    logic tx_s [128];
    logic bs_s [128];
    logic rd_s [128];

    uart_tx_cfg #(.DATA_WIDTH(8), .PRESCALE_W(16)) dut (
        .CLK(clk), .RST(rst), .data_in(din), .data_valid(dv), .data_ready(dr),
        .parity_EN(pen), .parity_type(pty), .stop2(s2), .prescale(pre),
        .TX_OUT(tx), .busy(bsy)
    );

    uart_tx_cfg #(.DATA_WIDTH(5), .PRESCALE_W(4)) dut5 (
        .CLK(clk), .RST(rst), .data_in(d5_din), .data_valid(d5_dv), .data_ready(d5_dr),
        .parity_EN(d5_pen), .parity_type(d5_pty), .stop2(d5_s2), .prescale(d5_pre),
        .TX_OUT(d5_tx), .busy(d5_bsy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records n samples starting now (the cycle just after the accepting edge).
    task automatic capture(input int n, input int which, input int drop_at);
        for (int i = 0; i < n; i++) begin
            if (i == drop_at) begin
                if (which == 0) dv = 1'b0;
                else d5_dv = 1'b0;
            end
            tx_s[i] = (which == 0) ? tx  : d5_tx;
            bs_s[i] = (which == 0) ? bsy : d5_bsy;
            rd_s[i] = (which == 0) ? dr  : d5_dr;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx got %b want 1", tx); end
        n_cmp++;
        if (bsy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bsy); end
        n_cmp++;
        if (dr !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", dr); end
        n_cmp++;
        if (d5_tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx5 got %b want 1", d5_tx); end
        n_cmp++;
        rst = 1'b0;
        #1;
        if (dr !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after got %b want 1", dr); end
        n_cmp++;
        step();
    endtask

    task automatic test_8n1();
        logic e [11];
        e = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
        din = 8'h55; pen = 0; pty = 0; s2 = 0; pre = 0; dv = 1;
        if (dr !== 1'b1) begin n_bad++; $display("FAIL 8n1_ready_idle got %b want 1", dr); end
        n_cmp++;
        step();
        dv = 0;
        capture(11, 0, -1);
        for (int i = 0; i < 11; i++) begin
            if (tx_s[i] !== e[i]) begin
                n_bad++; $display("FAIL 8n1_tx[%0d] got %b want %b", i, tx_s[i], e[i]);
            end
            n_cmp++;
            if (bs_s[i] !== (i < 10)) begin
                n_bad++; $display("FAIL 8n1_busy[%0d] got %b want %b", i, bs_s[i], i < 10);
            end
            n_cmp++;
        end
    endtask

    task automatic test_8e1();
        logic e [11];
        int lows;
        e = '{0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1};
        din = 8'hA3; pen = 1; pty = 0; s2 = 0; pre = 3; dv = 1;
        step();
        dv = 0;
        // Scramble inputs mid-frame; the latched settings must win.
        din = 8'hFF; pen = 0; pty = 1; s2 = 1; pre = 0;
        capture(45, 0, -1);
        lows = 0;
        for (int i = 0; i < 45; i++) begin
            logic want;
            want = (i < 44) ? e[i / 4] : 1'b1;
            if (tx_s[i] !== want) begin
                n_bad++; $display("FAIL 8e1_tx[%0d] got %b want %b", i, tx_s[i], want);
            end
            n_cmp++;
            if (rd_s[i] === 1'b0) lows++;
        end
        if (lows != 43) begin n_bad++; $display("FAIL 8e1_ready_low got %0d want 43", lows); end
        n_cmp++;
        if (bs_s[43] !== 1'b1 || bs_s[44] !== 1'b0) begin
            n_bad++; $display("FAIL 8e1_busy_end got %b%b want 10", bs_s[43], bs_s[44]);
        end
        n_cmp++;
    endtask

    task automatic test_8o2();
        logic e [12];
        e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
        din = 8'h00; pen = 1; pty = 1; s2 = 1; pre = 1; dv = 1;
        step();
        dv = 0;
        capture(25, 0, -1);
        for (int i = 0; i < 24; i++) begin
            if (tx_s[i] !== e[i / 2]) begin
                n_bad++; $display("FAIL 8o2_tx[%0d] got %b want %b", i, tx_s[i], e[i / 2]);
            end
            n_cmp++;
        end
        if (bs_s[23] !== 1'b1 || bs_s[24] !== 1'b0 || tx_s[24] !== 1'b1) begin
            n_bad++;
            $display("FAIL 8o2_end busy %b%b tx %b want busy 10 tx 1", bs_s[23], bs_s[24], tx_s[24]);
        end
        n_cmp++;
        if (rd_s[22] !== 1'b0 || rd_s[23] !== 1'b1) begin
            n_bad++; $display("FAIL 8o2_ready got %b%b want 01", rd_s[22], rd_s[23]);
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic e [21];
        e = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 1,
              0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1};
        din = 8'h12; pen = 0; pty = 0; s2 = 0; pre = 0; dv = 1;
        step();
        din = 8'h34;
        capture(21, 0, 10);
        for (int i = 0; i < 21; i++) begin
            if (tx_s[i] !== e[i]) begin
                n_bad++; $display("FAIL b2b_tx[%0d] got %b want %b", i, tx_s[i], e[i]);
            end
            n_cmp++;
            if (bs_s[i] !== (i < 20)) begin
                n_bad++; $display("FAIL b2b_busy[%0d] got %b want %b", i, bs_s[i], i < 20);
            end
            n_cmp++;
        end
        if (rd_s[9] !== 1'b1 || rd_s[10] !== 1'b0) begin
            n_bad++; $display("FAIL b2b_ready got %b%b want 10", rd_s[9], rd_s[10]);
        end
        n_cmp++;
    endtask

    task automatic test_width5();
        logic e [7];
        logic f [7];
        e = '{0, 1, 1, 1, 1, 1, 1};
        f = '{0, 0, 1, 0, 1, 0, 1};
        d5_din = 5'h1F; d5_pre = 4'h0; d5_dv = 1;
        step();
        d5_dv = 0;
        capture(8, 1, -1);
        for (int i = 0; i < 8; i++) begin
            logic want;
            want = (i < 7) ? e[i] : 1'b1;
            if (tx_s[i] !== want) begin
                n_bad++; $display("FAIL w5_tx[%0d] got %b want %b", i, tx_s[i], want);
            end
            n_cmp++;
        end
        if (bs_s[6] !== 1'b1 || bs_s[7] !== 1'b0) begin
            n_bad++; $display("FAIL w5_busy got %b%b want 10", bs_s[6], bs_s[7]);
        end
        n_cmp++;
        // All-ones prescale: 16 cycles per bit, no early wrap.
        d5_din = 5'h0A; d5_pre = 4'hF; d5_dv = 1;
        step();
        d5_dv = 0;
        capture(113, 1, -1);
        for (int i = 0; i < 113; i++) begin
            logic want;
            want = (i < 112) ? f[i / 16] : 1'b1;
            if (tx_s[i] !== want) begin
                n_bad++; $display("FAIL w5max_tx[%0d] got %b want %b", i, tx_s[i], want);
            end
            n_cmp++;
        end
        if (bs_s[112] !== 1'b0) begin
            n_bad++; $display("FAIL w5max_busy_end got %b want 0", bs_s[112]);
        end
        n_cmp++;
    endtask

    task automatic test_reset_mid();
        logic e [11];
        e = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};
        din = 8'h00; pen = 0; pty = 0; s2 = 0; pre = 3; dv = 1;
        step();
        dv = 0;
        capture(10, 0, -1);
        if (tx_s[9] !== 1'b0 || bs_s[9] !== 1'b1) begin
            n_bad++; $display("FAIL rmid_pre tx %b busy %b want 0 1", tx_s[9], bs_s[9]);
        end
        n_cmp++;
        rst = 1'b1;
        #1;
        if (dr !== 1'b0) begin n_bad++; $display("FAIL rmid_ready_in_rst got %b want 0", dr); end
        n_cmp++;
        step();
        if (tx !== 1'b1 || bsy !== 1'b0) begin
            n_bad++; $display("FAIL rmid_after tx %b busy %b want 1 0", tx, bsy);
        end
        n_cmp++;
        rst = 1'b0;
        #1;
        if (dr !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after got %b want 1", dr); end
        n_cmp++;
        din = 8'hA5; pre = 0; dv = 1;
        step();
        dv = 0;
        capture(11, 0, -1);
        for (int i = 0; i < 11; i++) begin
            if (tx_s[i] !== e[i]) begin
                n_bad++; $display("FAIL rmid_frame_tx[%0d] got %b want %b", i, tx_s[i], e[i]);
            end
            n_cmp++;
        end
    endtask

    initial begin
        rst = 1; din = 0; dv = 0; pen = 0; pty = 0; s2 = 0; pre = 0;
        d5_din = 0; d5_dv = 0; d5_pen = 0; d5_pty = 0; d5_s2 = 0; d5_pre = 0;
        #1;
        test_reset();
        test_8n1();
        test_8e1();
        test_8o2();
        test_back_to_back();
        test_width5();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
